// File: rtl/wb_bus_unit_pkg.sv
// Shared encodings for the write-back unit: bus-C select codes, load funct3
// codes and the skid-queue state encoding.
package wb_bus_unit_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_UI   = 2'b10;
  localparam logic [1:0] WB_PCUI = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [1:0] Q_EMPTY = 2'd0;
  localparam logic [1:0] Q_ONE   = 2'd1;
  localparam logic [1:0] Q_FULL  = 2'd2;

endpackage

// File: rtl/wb_bus_unit_if.sv
// Register-file write port: valid/ready handshake carrying destination and data.
// The write-back unit is the master, the register file is the slave.
interface wb_bus_unit_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            rf_valid_o;
  logic            rf_ready_i;
  logic [RA_W-1:0] rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;

  modport master (output rf_valid_o, output rf_waddr_o, output rf_wdata_o, input rf_ready_i);
  modport slave  (input rf_valid_o, input rf_waddr_o, input rf_wdata_o, output rf_ready_i);
endinterface

// File: rtl/wb_bus_unit_load_align.sv
// Sub-word load alignment: extracts the addressed lane from a naturally aligned
// word and sign/zero-extends it, flagging misaligned or unsupported widths.
module wb_load_align
  import wb_bus_unit_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFS_W = $clog2(XLEN/8)
) (
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  d_in_i,
  input  logic [OFS_W-1:0] addr_lo_i,
  output logic [XLEN-1:0]  data_o,
  output logic             illegal_o
);
  logic [XLEN-1:0] lane;

  // Shifting the addressed byte down to bit 0 makes every width a low slice.
  assign lane = d_in_i >> {addr_lo_i, 3'b000};

  // NOTE: both outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    data_o    = '0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = XLEN'($signed(lane[7:0]));
      F3_LBU: data_o = XLEN'(lane[7:0]);
      F3_LH: begin
        illegal_o = addr_lo_i[0];
        data_o    = XLEN'($signed(lane[15:0]));
      end
      F3_LHU: begin
        illegal_o = addr_lo_i[0];
        data_o    = XLEN'(lane[15:0]);
      end
      F3_LW: begin
        illegal_o = |addr_lo_i[1:0];
        data_o    = XLEN'($signed(lane[31:0]));
      end
      F3_LWU: begin
        illegal_o = (XLEN == 32) || (|addr_lo_i[1:0]);
        data_o    = XLEN'(lane[31:0]);
      end
      F3_LD: begin
        illegal_o = (XLEN == 32) || (|addr_lo_i);
        data_o    = lane;
      end
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/wb_bus_unit.sv
// Registered write-back select feeding a 2-entry skid queue toward the
// register-file write port, so issue can continue while the register file stalls.
module wb_bus_unit
  import wb_bus_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  localparam int OFS_W = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid_i,
  output logic              wb_ready_o,
  input  logic [1:0]        wb_sel_i,
  input  logic [2:0]        wb_funct3_i,
  input  logic [RA_W-1:0]   wb_rd_i,
  input  logic [XLEN-1:0]   alu_out_i,
  input  logic [XLEN-1:0]   d_in_i,
  input  logic [OFS_W-1:0]  addr_lo_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   ui_offset_i,
  wb_bus_unit_if.master     rf,
  output logic              err_o
);
  logic [XLEN-1:0] load_data, result;
  logic            load_illegal, accept, drop_bad, enq, deq;

  logic [1:0]      state_q, state_d;
  logic [RA_W-1:0] head_rd_q, head_rd_d, tail_rd_q, tail_rd_d;
  logic [XLEN-1:0] head_dat_q, head_dat_d, tail_dat_q, tail_dat_d;
  logic            ready_q, ready_d, err_q, err_d;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .funct3_i  (wb_funct3_i),
    .d_in_i    (d_in_i),
    .addr_lo_i (addr_lo_i),
    .data_o    (load_data),
    .illegal_o (load_illegal)
  );

  always_comb begin
    result = alu_out_i;
    case (wb_sel_i)
      WB_LOAD: result = load_data;
      WB_UI:   result = ui_offset_i;
      WB_PCUI: result = pc_i + ui_offset_i;
      default: result = alu_out_i;
    endcase
  end

  // Bad loads and writes to x0 are consumed without occupying a queue slot.
  assign accept   = wb_valid_i && ready_q;
  assign drop_bad = (wb_sel_i == WB_LOAD) && load_illegal;
  assign enq      = accept && !drop_bad && (wb_rd_i != '0);
  assign deq      = (state_q != Q_EMPTY) && rf.rf_ready_i;

  always_comb begin
    state_d    = state_q;
    head_rd_d  = head_rd_q;
    head_dat_d = head_dat_q;
    tail_rd_d  = tail_rd_q;
    tail_dat_d = tail_dat_q;
    case (state_q)
      Q_EMPTY: if (enq) begin
        head_rd_d  = wb_rd_i;
        head_dat_d = result;
        state_d    = Q_ONE;
      end
      Q_ONE: if (enq && deq) begin
        head_rd_d  = wb_rd_i;
        head_dat_d = result;
      end else if (enq) begin
        tail_rd_d  = wb_rd_i;
        tail_dat_d = result;
        state_d    = Q_FULL;
      end else if (deq) begin
        state_d    = Q_EMPTY;
      end
      Q_FULL: if (deq) begin
        head_rd_d  = tail_rd_q;
        head_dat_d = tail_dat_q;
        state_d    = Q_ONE;
      end
      default: state_d = Q_EMPTY;
    endcase
    ready_d = (state_d != Q_FULL);
    err_d   = accept && drop_bad;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  // NOTE: the queue storage is a pair of registers, so it is cleared on reset
  // to keep rf_waddr_o/rf_wdata_o at zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= Q_EMPTY;
      head_rd_q  <= '0;
      head_dat_q <= '0;
      tail_rd_q  <= '0;
      tail_dat_q <= '0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_rd_q  <= head_rd_d;
      head_dat_q <= head_dat_d;
      tail_rd_q  <= tail_rd_d;
      tail_dat_q <= tail_dat_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign wb_ready_o    = ready_q;
  assign err_o         = err_q;
  assign rf.rf_valid_o = (state_q != Q_EMPTY);
  assign rf.rf_waddr_o = head_rd_q;
  assign rf.rf_wdata_o = head_dat_q;
endmodule

// File: doc/wb_bus_unit.md
Name: wb_bus_unit

Overview:
Parametrised, registered successor to the combinational write-back (bus C) select of the multicycle RV core. It selects among ALU result, load data, U-immediate and PC+U-immediate, and aligns/sign-extends sub-word loads. Results are buffered in a 2-entry skid queue with a valid/ready handshake toward the register-file write port, so the control FSM can issue while the register file stalls. It sits between the datapath and the register-file write port.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 only.
RA_W, 5, register address width.
OFS_W, $clog2(XLEN/8), byte-offset width, derived and not overridden.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wb_valid_i  in  1  write-back request this cycle
wb_ready_o  out  1  unit can accept a request; registered
wb_sel_i  in  2  00 ALU, 01 load data, 10 UI_offset, 11 PC+UI_offset
wb_funct3_i  in  3  load width/sign; used only when wb_sel_i=01
wb_rd_i  in  RA_W  destination register
alu_out_i  in  XLEN  ALU result
d_in_i  in  XLEN  naturally aligned memory word/doubleword
addr_lo_i  in  OFS_W  low bits of the load address
pc_i  in  XLEN  PC of the instruction
ui_offset_i  in  XLEN  U-type immediate, pre-shifted
rf_valid_o  out  1  head entry valid
rf_ready_i  in  1  register file accepts the head entry
rf_waddr_o  out  RA_W  head destination
rf_wdata_o  out  XLEN  head data
err_o  out  1  one-cycle pulse: misaligned or illegal load dropped

Behaviour:
- Accept occurs when wb_valid_i && wb_ready_o, on the rising edge.
- Result selection:
  - sel 10: ui_offset_i.
  - sel 11: pc_i + ui_offset_i, modulo 2^XLEN.
  - sel 00: alu_out_i.
  - sel 01: load path below.
- Load path, with lane = byte addr_lo_i of d_in_i:
  - funct3 000 LB: sign-extend the byte.
  - funct3 100 LBU: zero-extend the byte.
  - funct3 001 LH: sign-extend the half at addr_lo_i; legal only if addr_lo_i[0]=0.
  - funct3 101 LHU: zero-extend the same half; same alignment rule.
  - funct3 010 LW: sign-extend the word at addr_lo_i; legal only if addr_lo_i[1:0]=0.
  - XLEN=64 only: 110 LWU zero-extends with the same rule as LW; 011 LD is legal only if addr_lo_i=0.
  - Any other funct3, any misalignment, or 011/110 when XLEN=32: the request is accepted but not enqueued; err_o=1 in the following cycle.
- Requests with wb_rd_i=0 are accepted and discarded; no error is raised.
- Queue is FIFO with states EMPTY, ONE, FULL. The head drives the rf_* outputs.
  - EMPTY: enq -> ONE.
  - ONE: enq without deq -> FULL; deq without enq -> EMPTY; enq and deq together -> ONE, with the new entry becoming the head.
  - FULL: deq -> ONE, with the second entry promoted to head. No enq is possible because wb_ready_o=0.
  - deq = rf_valid_o && rf_ready_i.
- wb_ready_o = (next state != FULL), registered. A simultaneous enq and deq in ONE keeps ready high.
- rf_valid_o=1 iff state != EMPTY. rf_waddr_o/rf_wdata_o hold stable while rf_valid_o && !rf_ready_i.
- Latency: accept at edge N -> rf_valid_o at edge N (registered output) -> earliest write at edge N+1.
- Reset, asynchronous and overriding everything including mid-transfer:
  - state EMPTY, rf_valid_o=0, wb_ready_o=1, err_o=0.
  - rf_waddr_o=0, rf_wdata_o=0, both queue entries zeroed.
  - In-flight entries are lost.
- A dropped request in the same cycle as a deq: the deq proceeds normally.
- Inputs are sampled only on the accept edge.

Decomposition:
- Shared package:
  - WB_ALU/WB_LOAD/WB_UI/WB_PCUI select encodings.
  - F3_LB..F3_LWU funct3 constants.
  - Queue state encoding.
- One sub-module, wb_load_align: combinational lane extract and extend with an illegal flag, parametrised by XLEN.
- The skid queue stays in the top.

Test Plan:
- sel=11, pc=0xFFFF_FFF0, ui=0x0000_0020, rf_ready_i=1 -> rf_wdata_o=0x0000_0010, rf_waddr_o=rd, rf_valid_o for 1 cycle.
- Loads with d_in_i=0x8070_F281 and rd=3:
  - LB, addr_lo=0 -> 0xFFFF_FF81.
  - LBU, addr_lo=1 -> 0x0000_00F2.
  - LH, addr_lo=2 -> 0xFFFF_8070.
  - LHU, addr_lo=2 -> 0x0000_8070.
- LW addr_lo=2, or LH addr_lo=1 -> nothing enqueued, err_o=1 for exactly 1 cycle, rf_valid_o stays 0.
- rf_ready_i=0, three back-to-back requests:
  - First two are accepted; wb_ready_o falls after the 2nd; the 3rd is held.
  - Raising rf_ready_i drains them in order A, B, then C.
  - Data is stable while stalled.
- State ONE with simultaneous enq and deq -> state stays ONE, wb_ready_o stays 1, the new entry is the next head.
- rst_n low mid-stream while FULL -> outputs go to 0 immediately (asynchronously), wb_ready_o=1, and no stale write after release.
- XLEN=64: LD with addr_lo=0 returns the full doubleword; LWU with addr_lo=4 and d_in=0x8000_0001_xxxx_xxxx -> 0x0000_0000_8000_0001.
